// File: rtl/mem_pkg.sv
// Shared widths and types for the 2R1W operand register file.
package mem_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/mem_2r1w_if.sv
// Write/read bus of the 2R1W register file; master drives requests, slave returns data.
interface mem_2r1w_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, read_addr1, read_addr2,
    input  read_data1, read_data2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, read_addr1, read_addr2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/mem_read_port.sv
// One registered read port with rd_en hold and a write-first bypass on address match.
module mem_read_port
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_arr_word,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);
  logic              w_bypass;
  logic [DATA_W-1:0] w_rd_next;
  logic [DATA_W-1:0] r_rd_data;

  // A same-edge write to the addressed entry wins over the stale array word.
  assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr);
  assign w_rd_next = w_bypass ? i_wr_data : i_arr_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= w_rd_next;
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/mem_2r1w.sv
// 2R1W register file: flop array with async clear, one write port, two registered read ports.
module mem_2r1w
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic       clk,
  input  logic       rst,
  mem_2r1w_if.slave  bus
);
  localparam int ARR_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [ARR_DEPTH];
  logic [DATA_W-1:0] w_arr_word1;
  logic [DATA_W-1:0] w_arr_word2;
  logic [DATA_W-1:0] w_rd_data1;
  logic [DATA_W-1:0] w_rd_data2;

  // Flops rather than a RAM macro so that reset can clear every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARR_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.wr_en) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign w_arr_word1 = r_mem[bus.read_addr1];
  assign w_arr_word2 = r_mem[bus.read_addr2];

  mem_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (bus.rd_en),
    .i_rd_addr  (bus.read_addr1),
    .i_arr_word (w_arr_word1),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .o_rd_data  (w_rd_data1)
  );

  mem_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (bus.rd_en),
    .i_rd_addr  (bus.read_addr2),
    .i_arr_word (w_arr_word2),
    .i_wr_en    (bus.wr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_data  (bus.wr_data),
    .o_rd_data  (w_rd_data2)
  );

  assign bus.read_data1 = w_rd_data1;
  assign bus.read_data2 = w_rd_data2;
endmodule

// File: tb/tb_mem_2r1w.sv
// Directed bench for mem_2r1w: scoreboard of expected read words, checked each cycle.
module tb_mem_2r1w;
  import mem_pkg::*;

  typedef struct packed {
    word_t d1;
    word_t d2;
  } exp_t;

  logic  clk;
  logic  rst;
  int    errors;
  int    checks;
  exp_t  sb[$];
  word_t model[DEPTH];
  word_t e1;
  word_t e2;

  mem_2r1w_if bus ();

  mem_2r1w dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic we, input addr_t wa, input word_t wd,
                      input logic re, input addr_t a1, input addr_t a2);
    exp_t got;
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.rd_en      = re;
    bus.read_addr1 = a1;
    bus.read_addr2 = a2;
    if (rst) begin
      e1 = '0;
      e2 = '0;
    end else begin
      if (re) begin
        e1 = (we && wa == a1) ? wd : model[a1];
        e2 = (we && wa == a2) ? wd : model[a2];
      end
      if (we) model[wa] = wd;
    end
    sb.push_back('{d1: e1, d2: e2});
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("rd1", bus.read_data1, got.d1);
    check("rd2", bus.read_data2, got.d2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    e1 = '0;
    e2 = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.read_addr1 = '0; bus.read_addr2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1", bus.read_data1, 32'h0);
    check("reset_rd2", bus.read_data2, 32'h0);

    // Write while in reset is lost.
    step(1'b1, 5'd18, 32'h40200000, 1'b1, 5'd18, 5'd18);
    rst = 1'b0;
    step(1'b1, 5'd13, 32'hC1433333, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd19, 32'h40A00000, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd19, 5'd13);
    check("r19_p1", bus.read_data1, 32'h40A00000);
    check("r13_p2", bus.read_data2, 32'hC1433333);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd19);
    check("r13_p1", bus.read_data1, 32'hC1433333);
    check("r19_p2", bus.read_data2, 32'h40A00000);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd18, 5'd18);
    check("r18_p1", bus.read_data1, 32'h0);
    check("r18_p2", bus.read_data2, 32'h0);

    // Hold with rd_en low.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd13);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 1'b0, addr_t'(i + 3), addr_t'(i + 20));
    check("hold_p1", bus.read_data1, 32'hC1433333);
    check("hold_p2", bus.read_data2, 32'hC1433333);

    // Write-first bypass.
    step(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd8);
    check("bypass_p1", bus.read_data1, 32'h22222222);
    check("bypass_p2", bus.read_data2, 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd7);
    check("after_bypass_p2", bus.read_data2, 32'h22222222);

    // wr_en low protects contents.
    for (int i = 0; i < 3; i++) step(1'b0, 5'd13, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    step(1'b0, 5'd13, 32'hFFFFFFFF, 1'b1, 5'd13, 5'd13);
    check("noweN_p1", bus.read_data1, 32'hC1433333);
    check("noweN_p2", bus.read_data2, 32'hC1433333);

    // Full sweep.
    for (int a = 0; a < DEPTH; a++)
      step(1'b1, addr_t'(a), word_t'(a * 32'h01010101), 1'b0, 5'd0, 5'd0);
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, addr_t'(a), addr_t'(31 - a));
      check("sweep_p1", bus.read_data1, word_t'(a * 32'h01010101));
      check("sweep_p2", bus.read_data2, word_t'((31 - a) * 32'h01010101));
    end

    // Asynchronous reset pulse between edges clears outputs immediately.
    #2;
    rst = 1'b1;
    #1;
    check("async_rd1", bus.read_data1, 32'h0);
    check("async_rd2", bus.read_data2, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    e1 = '0;
    e2 = '0;
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, addr_t'(a), addr_t'(31 - a));
      check("cleared_p1", bus.read_data1, 32'h0);
      check("cleared_p2", bus.read_data2, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
